// File: rtl/serial_add_responder_if.sv
// rtl/serial_add_responder_if.sv - request/response bundle for serial_add_responder
// Optional out_ovf member present when SERIAL_ADD_OVF_EN is defined.
interface serial_add_responder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, busy
`ifdef SERIAL_ADD_OVF_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_sum, out_carry, busy
`ifdef SERIAL_ADD_OVF_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/serial_add_responder.sv
// rtl/serial_add_responder.sv - bit-serial LSB-first adder behind valid/ready handshakes
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output out_ovf.
module serial_add_responder #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_add_responder_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [WIDTH-1:0] out_sum_r;
  logic             out_carry_r;
  logic             ovf_r;

  logic             a0;
  logic             b0;
  logic             sum_bit;
  logic             c_next;
  logic [WIDTH-1:0] sum_next;

  // One full-adder slice; the new sum bit enters from the MSB side.
  always_comb begin
    a0       = a_sr[0];
    b0       = b_sr[0];
    sum_bit  = a0 ^ b0 ^ carry;
    c_next   = (a0 & b0) | (carry & (a0 ^ b0));
    sum_next = (sum_sr >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      sum_sr      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_sum_r   <= '0;
      out_carry_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr       <= bus.in_a;
            b_sr       <= bus.in_b;
            carry      <= bus.in_c;
            sum_sr     <= '0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next;
          carry  <= c_next;
          cnt    <= cnt + CW'(1);
          // Result registers are only touched here so they stay stable otherwise.
          if (cnt == CW'(WIDTH - 1)) begin
            out_sum_r   <= sum_next;
            out_carry_r <= c_next;
            ovf_r       <= carry ^ c_next;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_carry = out_carry_r;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.out_ovf   = ovf_r;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_add_responder.sv
// tb/tb_serial_add_responder.sv - table-driven bench for serial_add_responder (WIDTH=8)
module tb_serial_add_responder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_responder_if #(.WIDTH(W)) bus ();
  serial_add_responder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input string tag);
    int n;
    logic [7:0] prev;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    prev = bus.out_sum;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_c = c;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a = ~a;
    bus.in_b = ~b;
    bus.in_c = ~c;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      if (n == W / 2) chk({tag, " sum_hold"}, 32'(bus.out_sum), 32'(prev));
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(W));
    chk({tag, " sum"}, 32'(bus.out_sum), 32'(es));
    chk({tag, " carry"}, 32'(bus.out_carry), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, " ovf"}, 32'(bus.out_ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected x in ovf vector %s", tag);
`endif
    chk({tag, " busy_done"}, 32'(bus.busy), 32'd1);
    chk({tag, " in_ready_done"}, 32'(bus.in_ready), 32'd0);
    if (bus.out_ready) begin
      @(negedge clk);
      chk({tag, " valid_drop"}, 32'(bus.out_valid), 32'd0);
      chk({tag, " in_ready_back"}, 32'(bus.in_ready), 32'd1);
      chk({tag, " busy_idle"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[8] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

    // Reset held with a request pending: nothing may be latched.
    bus.in_valid = 1'b1;
    bus.in_a = 8'h35;
    bus.in_b = 8'h1A;
    bus.in_c = 1'b1;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst out_carry", 32'(bus.out_carry), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst ovf", 32'(bus.out_ovf), 32'd0);
`endif
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst nothing_latched", 32'(bus.busy), 32'd0);
    chk("rst idle_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 9; i++)
      run_req(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sum, vecs[i].carry, vecs[i].ovf,
              $sformatf("vec%0d", i));

    // Backpressure: result must hold and new requests must be ignored.
    bus.out_ready = 1'b0;
    run_req(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "bp");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.in_a = 8'h11;
      bus.in_b = 8'h22;
      @(negedge clk);
      chk($sformatf("bp valid%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp sum%0d", i), 32'(bus.out_sum), 32'h00);
      chk($sformatf("bp carry%0d", i), 32'(bus.out_carry), 32'd1);
      chk($sformatf("bp in_ready%0d", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp release valid", 32'(bus.out_valid), 32'd0);
    chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
    run_req(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "bp_next");

    // DONE with out_ready and in_valid together: request waits for IDLE.
    bus.in_a = 8'h05;
    bus.in_b = 8'h06;
    bus.in_c = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (W - 1) @(negedge clk);
    chk("overlap pre_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("overlap valid", 32'(bus.out_valid), 32'd1);
    chk("overlap sum", 32'(bus.out_sum), 32'h0B);
    bus.in_a = 8'h20;
    bus.in_b = 8'h03;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("overlap not_accepted", 32'(bus.busy), 32'd0);
    chk("overlap idle_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("overlap accepted", 32'(bus.busy), 32'd1);
    repeat (W) @(negedge clk);
    chk("overlap2 valid", 32'(bus.out_valid), 32'd1);
    chk("overlap2 sum", 32'(bus.out_sum), 32'h23);
    @(negedge clk);

    // Reset in the middle of a calculation.
    bus.in_a = 8'hAA;
    bus.in_b = 8'h55;
    bus.in_c = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst out_sum", 32'(bus.out_sum), 32'd0);
    chk("midrst busy_clr", 32'(bus.busy), 32'd0);
    chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
    run_req(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
